// File: rtl/ddr2_pkg.sv
// Shared DDR2 timing/geometry constants for the read-return path and the init engine.
// The helper computes the column-wrapped address of beat idx in a sequential burst.
package ddr2_pkg;

  localparam int unsigned BL      = 8;
  localparam int unsigned CL      = 4;
  localparam int unsigned AL      = 3;
  localparam int unsigned PAD_DLY = 2;
  localparam int unsigned RL_CLK  = 2 * (AL + CL) + PAD_DLY;
  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned BL_LOG2 = $clog2(BL);
  localparam int unsigned AQ_AW   = 2;
  localparam logic        BT_SEQ  = 1'b0;

  typedef enum logic {
    CAP_IDLE,
    CAP_CAPTURE
  } cap_state_e;

  // Upper address bits never carry out of the burst column.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [BL_LOG2-1:0] idx);
    logic [BL_LOG2-1:0] col;
    col = base[BL_LOG2-1:0] + idx;
    return {base[ADDR_W-1:BL_LOG2], col};
  endfunction

endpackage

// File: rtl/ddr2_read_capture_fifo.sv
// Small first-word-fall-through FIFO; depth 2**AW, used as the read address queue.
module FIFO #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          put,
  input  logic          get,
  input  logic [DW-1:0] data_in,
  output logic          full_bar,
  output logic          empty_bar,
  output logic [DW-1:0] data_out
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic          do_put;
  logic          do_get;

  always_comb begin
    empty_bar = (wr_q != rd_q);
    full_bar  = !((wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]));
    do_put    = put && full_bar;
    do_get    = get && empty_bar;
    data_out  = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_put) wr_q <= wr_q + (AW+1)'(1);
      if (do_get) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_put) mem_q[wr_q[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/ddr2_read_capture.sv
// DDR2 read-return datapath: times read latency, captures BL DQ beats and pushes
// {column-wrapped address, data} into the return FIFO.
module ddr2_read_capture
  import ddr2_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_start,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        dq_in,
  input  logic [1:0]               dqs_in,
  input  logic                     ret_notfull,
  output logic                     ret_put,
  output logic [ADDR_W+DATA_W-1:0] ret_data,
  output logic                     rd_window,
  output logic                     busy,
  output logic                     err_spacing,
  output logic                     err_ovf,
  output logic                     err_dqs
);

  localparam int unsigned      SP_W   = $clog2(BL + 1);
  localparam int unsigned      BC_W   = BL_LOG2 + 1;
  localparam logic [SP_W-1:0]  SP_SAT = SP_W'(BL);
  localparam logic [BC_W-1:0]  BC_END = BC_W'(BL);

  logic [RL_CLK-1:0]        pipe_q, pipe_d;
  logic [SP_W-1:0]          space_q, space_d;
  cap_state_e               state_q, state_d;
  logic [BC_W-1:0]          beat_q, beat_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic                     put_q, put_d;
  logic [ADDR_W+DATA_W-1:0] data_q, data_d;
  logic                     spc_q, spc_d;
  logic                     ovf_q, ovf_d;
  logic                     dqs_err_q, dqs_err_d;

  logic              aq_full_bar;
  logic              aq_empty_bar;
  logic              aq_pop;
  logic [ADDR_W-1:0] aq_head;
  logic              space_ok;
  logic              accept;
  logic              tok_exit;
  logic              beat_done;
  logic              sample;
  logic [ADDR_W-1:0] beat_addr;

  FIFO #(
    .AW(AQ_AW),
    .DW(ADDR_W)
  ) u_addr_q (
    .clk      (clk),
    .reset    (reset),
    .put      (accept),
    .get      (aq_pop),
    .data_in  (rd_addr),
    .full_bar (aq_full_bar),
    .empty_bar(aq_empty_bar),
    .data_out (aq_head)
  );

  // Spacing counter saturates at BL; a saturated counter means "no recent start".
  always_comb begin
    space_ok = (space_q == SP_SAT);
    accept   = rd_start && space_ok && aq_full_bar;
    tok_exit = pipe_q[RL_CLK-1];
    pipe_d   = {pipe_q[RL_CLK-2:0], accept};
    if (accept) begin
      space_d = SP_W'(1);
    end else if (space_ok) begin
      space_d = space_q;
    end else begin
      space_d = space_q + SP_W'(1);
    end
  end

  // Beat 0 is sampled on the exit edge itself; beat_q==BL is a one-cycle tail
  // so a token exiting right after the last beat continues the burst gaplessly.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    aq_pop    = 1'b0;
    sample    = 1'b0;
    beat_addr = '0;
    beat_done = (beat_q == BC_END);
    if (tok_exit && ((state_q == CAP_IDLE) || beat_done)) begin
      aq_pop    = 1'b1;
      sample    = 1'b1;
      base_d    = aq_head;
      beat_addr = aq_head;
      beat_d    = BC_W'(1);
      state_d   = CAP_CAPTURE;
    end else if (state_q == CAP_CAPTURE) begin
      if (beat_done) begin
        state_d = CAP_IDLE;
        beat_d  = '0;
      end else begin
        sample    = 1'b1;
        beat_addr = burst_addr(base_q, beat_q[BL_LOG2-1:0]);
        beat_d    = beat_q + BC_W'(1);
      end
    end
  end

  always_comb begin
    put_d     = sample && ret_notfull;
    data_d    = put_d ? {beat_addr, dq_in} : data_q;
    spc_d     = rd_start && !accept;
    ovf_d     = ovf_q || (sample && !ret_notfull);
    dqs_err_d = dqs_err_q || (sample && (dqs_in[0] != dqs_in[1]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q    <= '0;
      space_q   <= SP_SAT;
      state_q   <= CAP_IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      put_q     <= 1'b0;
      data_q    <= '0;
      spc_q     <= 1'b0;
      ovf_q     <= 1'b0;
      dqs_err_q <= 1'b0;
    end else begin
      pipe_q    <= pipe_d;
      space_q   <= space_d;
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      put_q     <= put_d;
      data_q    <= data_d;
      spc_q     <= spc_d;
      ovf_q     <= ovf_d;
      dqs_err_q <= dqs_err_d;
    end
  end

  assign ret_put     = put_q;
  assign ret_data    = data_q;
  assign err_spacing = spc_q;
  assign err_ovf     = ovf_q;
  assign err_dqs     = dqs_err_q;
  assign rd_window   = pipe_q[RL_CLK-1] || (state_q == CAP_CAPTURE);
  assign busy        = (|pipe_q) || aq_empty_bar || (state_q == CAP_CAPTURE);

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    aq_pop |-> aq_empty_bar);
  a_no_lost_token: assert property (@(posedge clk) disable iff (reset)
    tok_exit |-> ((state_q == CAP_IDLE) || beat_done));

endmodule

// File: tb/tb_ddr2_read_capture.sv
// Self-checking bench for ddr2_read_capture: a list-of-reads model predicts every
// output each cycle; directed scenarios add literal expectations on top.
module tb_ddr2_read_capture;
  import ddr2_pkg::*;

  localparam int RL  = int'(RL_CLK);
  localparam int BLN = int'(BL);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     rd_start;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        dq_in;
  logic [1:0]               dqs_in;
  logic                     ret_notfull;
  logic                     ret_put;
  logic [ADDR_W+DATA_W-1:0] ret_data;
  logic                     rd_window;
  logic                     busy;
  logic                     err_spacing;
  logic                     err_ovf;
  logic                     err_dqs;

  always #5 clk = ~clk;

  ddr2_read_capture dut (
    .clk        (clk),
    .reset      (reset),
    .rd_start   (rd_start),
    .rd_addr    (rd_addr),
    .dq_in      (dq_in),
    .dqs_in     (dqs_in),
    .ret_notfull(ret_notfull),
    .ret_put    (ret_put),
    .ret_data   (ret_data),
    .rd_window  (rd_window),
    .busy       (busy),
    .err_spacing(err_spacing),
    .err_ovf    (err_ovf),
    .err_dqs    (err_dqs)
  );

  typedef struct { int s; logic [ADDR_W-1:0] a; } rd_t;
  typedef struct { int e; logic [ADDR_W+DATA_W-1:0] d; } put_t;

  rd_t  starts[$];
  put_t put_log[$];
  int   edge_n = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_acc = -1000;
  int   spc_pulses = 0;
  int   win_cnt = 0;

  logic                     exp_put, exp_win, exp_busy, exp_spc;
  logic                     exp_ovf = 1'b0;
  logic                     exp_dqs = 1'b0;
  logic [ADDR_W+DATA_W-1:0] exp_data;

  bit          rand_mode = 0;
  bit          dq_ramp = 0;
  logic [15:0] dq_base = 16'h0;
  int          dq_ref = 0;
  int          nf_lo = -1;
  int          nf_hi = -2;
  int          dqs_bad_edge = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a, input int i);
    longint unsigned base, col;
    base = longint'(a) - (longint'(a) % BLN);
    col  = ((longint'(a) % BLN) + i) % BLN;
    return ADDR_W'(base + col);
  endfunction

  task automatic model_step();
    bit hit;
    bit acc;
    int i;
    int occ;
    logic [ADDR_W-1:0] a;
    if (reset) begin
      starts.delete();
      last_acc = -1000;
      exp_put = 0; exp_win = 0; exp_busy = 0; exp_spc = 0; exp_ovf = 0; exp_dqs = 0;
      exp_data = '0;
      return;
    end
    hit = 0; i = 0; a = '0;
    foreach (starts[k])
      if (edge_n >= starts[k].s + RL && edge_n <= starts[k].s + RL + BLN - 1) begin
        hit = 1; i = edge_n - starts[k].s - RL; a = starts[k].a;
      end
    exp_put = hit && ret_notfull;
    if (exp_put) exp_data = {wrap(a, i), dq_in};
    if (hit && !ret_notfull) exp_ovf = 1;
    if (hit && (dqs_in[0] !== dqs_in[1])) exp_dqs = 1;
    occ = 0;
    foreach (starts[k]) if (starts[k].s + RL >= edge_n) occ++;
    acc = rd_start && (edge_n - last_acc >= BLN) && (occ < 4);
    if (acc) begin
      starts.push_back('{s: edge_n, a: rd_addr});
      last_acc = edge_n;
    end
    exp_spc = rd_start && !acc;
    exp_win = 0; exp_busy = 0;
    foreach (starts[k]) begin
      if (edge_n >= starts[k].s + RL - 1 && edge_n <= starts[k].s + RL + BLN - 1) exp_win = 1;
      if (edge_n >= starts[k].s && edge_n <= starts[k].s + RL + BLN - 1) exp_busy = 1;
    end
    while (starts.size() > 0 && starts[0].s + RL + BLN - 1 < edge_n) void'(starts.pop_front());
  endtask

  task automatic compare_outputs();
    chk("ret_put", ret_put, exp_put);
    if (exp_put) chk("ret_data", ret_data, exp_data);
    chk("rd_window", rd_window, exp_win);
    chk("busy", busy, exp_busy);
    chk("err_spacing", err_spacing, exp_spc);
    chk("err_ovf", err_ovf, exp_ovf);
    chk("err_dqs", err_dqs, exp_dqs);
    if (ret_put) put_log.push_back('{e: edge_n, d: ret_data});
    if (err_spacing) spc_pulses++;
    if (rd_window) win_cnt++;
  endtask

  always @(posedge clk) begin
    edge_n++;
    model_step();
    #1;
    compare_outputs();
  end

  task automatic tick();
    @(negedge clk);
    rd_start = 1'b0;
    reset    = 1'b0;
    if (rand_mode) begin
      dq_in       = 16'($urandom);
      ret_notfull = ($urandom_range(0, 19) != 0);
      dqs_in      = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      if ($urandom_range(0, 29) == 0) dqs_in = 2'b10;
    end else begin
      dq_in       = dq_ramp ? dq_base + 16'(edge_n + 1 - dq_ref) : 16'h0;
      ret_notfull = !((edge_n + 1 >= nf_lo) && (edge_n + 1 <= nf_hi));
      dqs_in      = (edge_n + 1 == dqs_bad_edge) ? 2'b01 : 2'b11;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      reset = 1'b1;
    end
  endtask

  task automatic start(input logic [ADDR_W-1:0] a, output int s);
    tick();
    rd_start = 1'b1;
    rd_addr  = a;
    s = edge_n + 1;
  endtask

  function automatic int puts_from(input int e0);
    int n = 0;
    foreach (put_log[k]) if (put_log[k].e >= e0) n++;
    return n;
  endfunction

  initial begin
    int s, s2;
    int lowseq[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    reset = 1'b1; rd_start = 1'b0; rd_addr = '0; dq_in = '0; dqs_in = 2'b11; ret_notfull = 1'b1;
    do_reset(3);
    tick();
    chk("reset_outputs", {ret_put, rd_window, busy, err_spacing, err_ovf, err_dqs}, 6'b0);
    chk("reset_data", ret_data, '0);
    idle(10);

    // 1: single read, ramp data, column wrap from 5
    put_log.delete();
    dq_ramp = 1; dq_base = 16'hA000;
    start(25'h0000005, s);
    dq_ref = s + RL;
    idle(30);
    chk("t1_puts", put_log.size(), 8);
    for (int k = 0; k < put_log.size() && k < 8; k++) begin
      chk("t1_latency", put_log[k].e - s, 16 + k);
      chk("t1_raddr", put_log[k].d[40:16], 25'(lowseq[k]));
      chk("t1_data", put_log[k].d[15:0], 16'hA000 + 16'(k));
    end

    // 2: back-to-back gapless
    put_log.delete(); win_cnt = 0;
    start(25'h10, s);
    idle(7);
    start(25'h20, s2);
    idle(30);
    chk("t2_puts", put_log.size(), 16);
    if (put_log.size() == 16) begin
      chk("t2_contiguous", put_log[15].e - put_log[0].e, 15);
      chk("t2_last_of_first", put_log[7].d[40:16], 25'h17);
      chk("t2_first_of_second", put_log[8].d[40:16], 25'h20);
    end
    chk("t2_window_len", win_cnt, 17);

    // 3: second start too close
    put_log.delete(); spc_pulses = 0;
    start(25'h40, s);
    idle(4);
    start(25'h48, s2);
    idle(30);
    chk("t3_spacing_pulses", spc_pulses, 1);
    chk("t3_puts", put_log.size(), 8);

    // 4: return FIFO full during beats 3-4
    put_log.delete();
    start(25'h2, s);
    nf_lo = s + RL + 3; nf_hi = s + RL + 4;
    idle(30);
    chk("t4_puts", put_log.size(), 6);
    if (put_log.size() == 6) begin
      chk("t4_beat5_edge", put_log[3].e - s, 21);
      chk("t4_beat5_raddr", put_log[3].d[40:16], 25'h7);
      chk("t4_beat7_raddr", put_log[5].d[40:16], 25'h1);
    end
    chk("t4_ovf", err_ovf, 1'b1);
    nf_lo = -1; nf_hi = -2;
    idle(10);
    chk("t4_ovf_sticky", err_ovf, 1'b1);

    // 5: reset mid-burst
    do_reset(2);
    idle(10);
    put_log.delete();
    start(25'h100, s);
    idle(19);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_zero", {ret_put, rd_window, busy, err_spacing, err_ovf, err_dqs}, 6'b0);
    idle(30);
    chk("t5_before_reset", put_log.size(), 4);
    chk("t5_stray", puts_from(s + RL + 4), 0);
    start(25'h200, s2);
    idle(30);
    chk("t5_fresh_puts", puts_from(s2), 8);

    // 6: DQS mismatch off-beat is ignored, on-beat is sticky
    do_reset(2);
    dqs_bad_edge = edge_n + 3;
    idle(6);
    chk("t6_offbeat", err_dqs, 1'b0);
    put_log.delete();
    start(25'h300, s);
    dqs_bad_edge = s + RL + 2;
    idle(30);
    chk("t6_dqs", err_dqs, 1'b1);
    chk("t6_puts", put_log.size(), 8);
    dqs_bad_edge = -1;
    idle(5);
    chk("t6_dqs_sticky", err_dqs, 1'b1);

    // Randomized traffic against the model
    do_reset(2);
    idle(10);
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1 + $urandom_range(0, 1));
        idle(BLN + 2);
      end else begin
        tick();
        if ($urandom_range(0, 5) == 0) begin
          rd_start = 1'b1;
          rd_addr  = ADDR_W'($urandom);
        end
      end
    end
    rand_mode = 0;
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
